// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner
//   LED scanner with one lit head and a trailing tail. A built-in prescaler
//   moves the head across N_LEDS outputs at a rate set at runtime. There are
//   four modes: bounce (ping-pong), wrap-up, wrap-down and hold.
//
// Parameters
//   N_LEDS  number of LED outputs (>= 2)
//   TAIL    number of lit LEDs behind the head (0 .. N_LEDS-1)
//   DIV_W   width of the prescaler compare value and counter
//
// Ports
//   clk      fabric clock; all logic runs on posedge
//   rst      synchronous reset, active high; overrides en
//   en       1 = prescaler and stepping run, 0 = all state is frozen
//   mode     00 bounce, 01 wrap-up, 10 wrap-down, 11 hold
//   div      step period minus 1, in clk cycles
//   led_out  registered LED pattern
//   dir_out  current direction: 0 = up (toward MSB), 1 = down
//   step     one-cycle pulse on the cycle the head has just moved
// ---------------------------------------------------------------------------
module led_scanner #(
    parameter int N_LEDS = 8,
    parameter int TAIL   = 2,
    parameter int DIV_W  = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    output logic [N_LEDS-1:0] led_out,
    output logic              dir_out,
    output logic              step
);

    localparam int          POS_W  = $clog2(N_LEDS);
    localparam int unsigned N_U    = N_LEDS;
    localparam int unsigned TAIL_U = TAIL;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_W-1:0]  cnt;
    logic [POS_W-1:0]  pos;
    dir_t              dir;

    mode_t             mode_q;
    logic              tick;
    logic              moving;
    logic              wrap;
    logic [POS_W-1:0]  pos_nxt;
    dir_t              dir_nxt;
    logic [N_LEDS-1:0] pat_nxt;

    // Next head position and direction on a prescaler tick.
    always_comb begin
        mode_q  = mode_t'(mode);
        tick    = en && (cnt >= div);
        moving  = 1'b0;
        wrap    = 1'b0;
        pos_nxt = pos;
        dir_nxt = dir;
        if (tick) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    moving = 1'b1;
                    if (dir == DIR_UP) begin
                        if (pos == POS_MAX) begin
                            dir_nxt = DIR_DOWN;
                            pos_nxt = POS_MAX - 1'b1;
                        end else begin
                            pos_nxt = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_nxt = DIR_UP;
                            pos_nxt = POS_W'(1);
                        end else begin
                            pos_nxt = pos - 1'b1;
                        end
                    end
                end
                MODE_WRAP_UP: begin
                    moving  = 1'b1;
                    wrap    = 1'b1;
                    dir_nxt = DIR_UP;
                    pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
                end
                MODE_WRAP_DOWN: begin
                    moving  = 1'b1;
                    wrap    = 1'b1;
                    dir_nxt = DIR_DOWN;
                    pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
                end
                default: begin
                    moving = 1'b0;
                end
            endcase
        end
    end

    // Pattern built from the next head/direction so that led_out lands on
    // the same edge as pos/dir. Tail bits trail opposite to the direction;
    // they wrap in the wrap modes and are dropped at the ends otherwise.
    always_comb begin
        pat_nxt          = '0;
        pat_nxt[pos_nxt] = 1'b1;
        for (int unsigned k = 1; k < N_U; k++) begin
            if (k <= TAIL_U) begin
                if (dir_nxt == DIR_UP) begin
                    if (wrap)
                        pat_nxt[POS_W'((32'(pos_nxt) + N_U - k) % N_U)] = 1'b1;
                    else if (32'(pos_nxt) >= k)
                        pat_nxt[POS_W'(32'(pos_nxt) - k)] = 1'b1;
                end else begin
                    if (wrap)
                        pat_nxt[POS_W'((32'(pos_nxt) + k) % N_U)] = 1'b1;
                    else if (32'(pos_nxt) + k < N_U)
                        pat_nxt[POS_W'(32'(pos_nxt) + k)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            step    <= 1'b0;
            led_out <= N_LEDS'(1);
        end else if (en) begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            pos  <= pos_nxt;
            dir  <= dir_nxt;
            step <= moving;
            // Hold mode leaves the displayed pattern exactly as it was.
            if (moving)
                led_out <= pat_nxt;
        end else begin
            step <= 1'b0;
        end
    end

    always_comb dir_out = (dir == DIR_DOWN);

endmodule

// File: tb/tb_led_scanner.sv
module tb_led_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [26:0] div  = '0;

    logic [7:0]  led_a;
    logic        dir_a, step_a;
    logic [3:0]  led_b;
    logic        dir_b, step_b;

    int checks = 0;
    int errors = 0;

    // reference model state: instance A (8 LEDs, tail 2), instance B (4 LEDs, tail 0)
    int         pa = 0, da = 0, ca = 0;
    logic [7:0] la = 8'h01;
    bit         sa = 0;
    int         pb = 0, db = 0, cb = 0;
    logic [7:0] lb = 8'h01;
    bit         sb = 0;

    led_scanner #(.N_LEDS(8), .TAIL(2), .DIV_W(27)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .led_out(led_a), .dir_out(dir_a), .step(step_a)
    );

    led_scanner #(.N_LEDS(4), .TAIL(0), .DIV_W(27)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .led_out(led_b), .dir_out(dir_b), .step(step_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lit set: head plus TAIL LEDs behind it (opposite to travel), wrapped or clipped.
    function automatic logic [7:0] pattern(input int n, input int tail, input int p,
                                           input int d, input bit wrap);
        logic [7:0] r;
        int idx;
        r = 8'(1) << p;
        for (int k = 1; k <= tail; k++) begin
            idx = (d == 0) ? p - k : p + k;
            if (wrap) idx = (idx + n) % n;
            if (idx >= 0 && idx < n) r = r | (8'(1) << idx);
        end
        return r;
    endfunction

    task automatic model(input int n, input int tail,
                         input int pi, input int di, input int ci, input logic [7:0] li,
                         output int po, output int dout, output int co,
                         output logic [7:0] lo, output bit so);
        bit tk;
        po = pi; dout = di; co = ci; lo = li; so = 0;
        if (rst) begin
            po = 0; dout = 0; co = 0; lo = 8'h01;
        end else if (en) begin
            tk = (ci >= int'(div));
            co = tk ? 0 : ci + 1;
            if (tk && mode != 2'd3) begin
                case (mode)
                    2'd0: begin
                        if (di == 0) begin
                            if (pi == n - 1) begin dout = 1; po = n - 2; end
                            else po = pi + 1;
                        end else begin
                            if (pi == 0) begin dout = 0; po = 1; end
                            else po = pi - 1;
                        end
                    end
                    2'd1: begin dout = 0; po = (pi + 1) % n; end
                    default: begin dout = 1; po = (pi + n - 1) % n; end
                endcase
                lo = pattern(n, tail, po, dout, mode != 2'd0);
                so = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model(8, 2, pa, da, ca, la, pa, da, ca, la, sa);
        model(4, 0, pb, db, cb, lb, pb, db, cb, lb, sb);
        #1;
        chk("led_a",  32'(led_a),  32'(la));
        chk("dir_a",  32'(dir_a),  32'(da));
        chk("step_a", 32'(step_a), 32'(sa));
        chk("led_b",  32'(led_b),  32'(lb));
        chk("dir_b",  32'(dir_b),  32'(db));
        chk("step_b", 32'(step_b), 32'(sb));
    endtask

    logic [7:0] t1_a [11];
    logic [3:0] t1_b [11];
    int nsteps;
    int first;

    initial begin
        t1_a = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC0, 8'hE0, 8'h70};
        t1_b = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};

        // T1 / T6 bounce: reset, then step every cycle
        rst = 1; en = 1; mode = 2'b00; div = 0;
        cyc();
        chk("t1_reset_led", 32'(led_a), 32'h01);
        chk("t1_reset_step", 32'(step_a), 32'h0);
        rst = 0;
        for (int i = 1; i < 11; i++) begin
            cyc();
            chk("t1_led_a", 32'(led_a), 32'(t1_a[i]));
            chk("t1_dir_a", 32'(dir_a), (i >= 8) ? 32'h1 : 32'h0);
            chk("t1_step_a", 32'(step_a), 32'h1);
            chk("t6_led_b", 32'(led_b), 32'(t1_b[i]));
        end

        // T3: wrap-up from head 7, then wrap-down
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 7; i++) cyc();
        chk("t3_start", 32'(led_a), 32'hE0);
        mode = 2'b01;
        cyc(); chk("t3_wrap_up0", 32'(led_a), 32'hC1);
        cyc(); chk("t3_wrap_up1", 32'(led_a), 32'h83);
        mode = 2'b10;
        cyc(); chk("t3b_wrap_dn0", 32'(led_a), 32'h07);
        cyc(); chk("t3b_wrap_dn1", 32'(led_a), 32'h83);
        chk("t3b_dir", 32'(dir_a), 32'h1);

        // T2: div=3, one step per 4 cycles
        mode = 2'b00; div = 3;
        nsteps = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (step_a) nsteps++;
        end
        chk("t2_step_count", 32'(nsteps), 32'd4);

        // T4: freeze, resume, then hold mode
        cyc(); cyc();
        en = 0;
        for (int i = 0; i < 10; i++) cyc();
        en = 1;
        for (int i = 0; i < 8; i++) cyc();
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t4_hold_step", 32'(step_a), 32'h0);
        end

        // T5: reset mid-scan while heading down with cnt=3
        mode = 2'b00; div = 5;
        for (int i = 0; i < 300 && !(da == 1 && ca == 3); i++) cyc();
        rst = 1; cyc(); rst = 0;
        chk("t5_led", 32'(led_a), 32'h01);
        chk("t5_dir", 32'(dir_a), 32'h0);
        chk("t5_step", 32'(step_a), 32'h0);
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            cyc();
            if (step_a) first = i;
        end
        chk("t5_first_step", 32'(first), 32'd6);

        // T6: lower div below cnt -> tick on the next cycle
        div = 9; rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 6; i++) cyc();
        div = 2;
        cyc();
        chk("t6_div_lower_step", 32'(step_b), 32'h1);
        chk("t6_div_lower_led", 32'(led_b), 32'h2);

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) div = 27'($urandom_range(0, 4));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
